// File: rtl/sram_ctrl.sv
// Registered request/response front end for a 256K x 16 asynchronous SRAM.
// Optional macro SRAM_CTRL_WAIT_EN stretches the WE_N pulse and the read access by one cycle.
`timescale 1ns/1ps
module sram_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N
);
  typedef enum logic [2:0] {IDLE, WR, WR_WAIT, WR_END, RD, RD_WAIT, RD_CAP} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, rd_mask;
  logic              rvalid_q, dq_oe_q;
  logic              ce_n_q, we_n_q, oe_n_q, ub_n_q, lb_n_q;

  // Lane selects double as the latched byte enables for masking read data.
  assign rd_mask = {{(DATA_W/2){~ub_n_q}}, {(DATA_W/2){~lb_n_q}}};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          ub_n_q  <= ~req_be[1];
          lb_n_q  <= ~req_be[0];
          ce_n_q  <= 1'b0;
          if (req_we) begin
            state_q <= WR;
            we_n_q  <= 1'b0;
            dq_oe_q <= 1'b1;
          end else begin
            state_q <= RD;
            oe_n_q  <= 1'b0;
          end
        end
`ifdef SRAM_CTRL_WAIT_EN
        WR:      state_q <= WR_WAIT;
        WR_WAIT: begin
          state_q <= WR_END;
          we_n_q  <= 1'b1;
        end
        RD:      state_q <= RD_WAIT;
        RD_WAIT: state_q <= RD_CAP;
`else
        WR: begin
          state_q <= WR_END;
          we_n_q  <= 1'b1;
        end
        RD:      state_q <= RD_CAP;
`endif
        // Data stays driven one cycle past the WE_N rising edge for hold time.
        WR_END: begin
          state_q <= IDLE;
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
        end
        RD_CAP: begin
          state_q  <= IDLE;
          rdata_q  <= SRAM_DQ & rd_mask;
          rvalid_q <= 1'b1;
          ce_n_q   <= 1'b1;
          oe_n_q   <= 1'b1;
          ub_n_q   <= 1'b1;
          lb_n_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE) && !reset;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_CE_N = ce_n_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: async SRAM model on the pins, transaction-level reference model, per-cycle compare.
`timescale 1ns/1ps
module tb_sram_ctrl;
`ifdef SRAM_CTRL_WAIT_EN
  localparam int S = 4;
`else
  localparam int S = 3;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset, req, req_we;
  logic [17:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        ready, rvalid;
  logic [15:0] rdata;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N;

  sram_ctrl dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .ready(ready), .rdata(rdata), .rvalid(rvalid),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_CE_N(SRAM_CE_N)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Physical SRAM: drives enabled lanes while reading, stores enabled lanes while WE_N is low.
  logic [15:0] mem [0:(1<<18)-1];
  wire sram_rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign SRAM_DQ[15:8] = (sram_rd && !SRAM_UB_N) ? mem[SRAM_ADDR][15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (sram_rd && !SRAM_LB_N) ? mem[SRAM_ADDR][7:0]  : 8'hzz;
  always @(negedge CLOCK_50)
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
    end

  int tests = 0, fails = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Undriven bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
  task automatic check_z(input string nm);
    tests++;
    if (!(SRAM_DQ === 16'hzzzz || SRAM_DQ === 16'h0000)) begin
      fails++;
      $display("FAIL %s: got %h, required Z (t=%0t)", nm, SRAM_DQ, $time);
    end
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // Reference model: an access occupies S-1 edges after acceptance; read data lands on the last.
  logic [15:0] ref_mem [0:(1<<18)-1];
  int          cyc = 0, p_m = 0, acc_cnt = 0, issued = 0;
  bit          busy_m = 0, we_m = 0, rv_m = 0;
  logic [17:0] addr_m = '0;
  logic [15:0] wd_m = '0, rdata_m = '0;
  logic [1:0]  be_m = '0;

  always @(posedge CLOCK_50) begin
    cyc++;
    rv_m = 0;
    if (reset) begin
      busy_m  = 0;
      rdata_m = '0;
    end else if (busy_m) begin
      p_m++;
      if (p_m == S-1) begin
        busy_m = 0;
        if (!we_m) begin
          rdata_m = ref_mem[addr_m] & lane_mask(be_m);
          rv_m    = 1;
        end
      end
    end else if (req) begin
      busy_m = 1; p_m = 0; acc_cnt++;
      we_m = req_we; addr_m = req_addr; wd_m = req_wdata; be_m = req_be;
      if (req_we)
        ref_mem[req_addr] = (ref_mem[req_addr] & ~lane_mask(req_be)) | (req_wdata & lane_mask(req_be));
    end
  end

  always @(negedge CLOCK_50) if (chk_en) begin
    check("ready",  ready,     !busy_m && !reset);
    check("rvalid", rvalid,    rv_m);
    check("rdata",  rdata,     rdata_m);
    check("ce_n",   SRAM_CE_N, !busy_m);
    check("we_n",   SRAM_WE_N, !(busy_m && we_m && p_m < S-2));
    check("oe_n",   SRAM_OE_N, !(busy_m && !we_m));
    if (busy_m) begin
      check("addr", SRAM_ADDR, addr_m);
      check("ub_n", SRAM_UB_N, !be_m[1]);
      check("lb_n", SRAM_LB_N, !be_m[0]);
      if (we_m) check("dq_wr", SRAM_DQ, wd_m);
    end else check_z("dq_idle");
  end

  int          we_lo = 0, rv_cnt = 0, rv_cyc = 0;
  logic [15:0] rv_data = '0;
  always @(negedge CLOCK_50) begin
    if (!SRAM_WE_N) we_lo++;
    if (rvalid) begin
      rv_cnt++;
      rv_cyc  = cyc;
      rv_data = rdata;
    end
  end

  task automatic issue(input logic we, input logic [17:0] a, input logic [15:0] d,
                       input logic [1:0] be, input bit hold);
    int n = 0;
    req = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    @(negedge CLOCK_50);
    while (!ready && n < 20) begin n++; @(negedge CLOCK_50); end
    tests++;
    if (!ready) begin
      fails++;
      $display("FAIL issue_timeout: ready=0 after %0d cycles, required 1", n);
      req = 0;
      return;
    end
    @(posedge CLOCK_50); #1;
    issued++;
    if (!hold) req = 0;
  endtask

  task automatic rd_check(input string nm, input logic [17:0] a, input logic [1:0] be,
                          input logic [15:0] exp);
    int c0 = rv_cnt;
    issue(0, a, 16'h0, be, 0);
    repeat (S) @(posedge CLOCK_50);
    #1;
    check({nm, "_pulses"}, rv_cnt - c0, 1);
    check(nm, rv_data, exp);
  endtask

  initial begin
    int a0, c0, prev;
    for (int i = 0; i < (1<<18); i++) begin mem[i] = '0; ref_mem[i] = '0; end
    // Requests presented during reset must be ignored.
    reset = 1; req = 1; req_we = 1; req_addr = 18'd7; req_wdata = 16'hDEAD; req_be = 2'b11;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk_en = 1;
    check("rst_rdata", rdata, 16'h0);
    check("rst_rvalid", rvalid, 0);
    check("rst_ce_n", SRAM_CE_N, 1);
    check("rst_we_n", SRAM_WE_N, 1);
    check("rst_oe_n", SRAM_OE_N, 1);
    check("rst_ub_lb", {SRAM_UB_N, SRAM_LB_N}, 2'b11);
    check("rst_addr", SRAM_ADDR, 18'h0);
    check("rst_ready", ready, 0);
    check_z("rst_dq");
    req = 0; reset = 0; #1;
    check("rst_rel_ready", ready, 1);

    // Write 13 <- 0002, then read it back.
    we_lo = 0;
    issue(1, 18'd13, 16'h0002, 2'b11, 0);
    check("s1_dq", SRAM_DQ, 16'h0002);
    check("s1_addr", SRAM_ADDR, 18'd13);
    check("s1_we_n", SRAM_WE_N, 0);
    repeat (S) @(posedge CLOCK_50);
    #1;
`ifdef SRAM_CTRL_WAIT_EN
    check("s1_we_low_cycles", we_lo, 2);
`else
    check("s1_we_low_cycles", we_lo, 1);
`endif
    c0 = rv_cnt;
    issue(0, 18'd13, 16'h0, 2'b11, 0);
    a0 = cyc;
    repeat (S) @(posedge CLOCK_50);
    #1;
    check("s1_pulses", rv_cnt - c0, 1);
`ifdef SRAM_CTRL_WAIT_EN
    check("s1_latency", rv_cyc - a0, 3);
`else
    check("s1_latency", rv_cyc - a0, 2);
`endif
    check("s1_rdata", rv_data, 16'h0002);

    // Byte-lane merging.
    issue(1, 18'd5, 16'hFFFF, 2'b11, 0);
    issue(1, 18'd5, 16'h1234, 2'b01, 0);
    rd_check("be11_rd", 18'd5, 2'b11, 16'hFF34);
    rd_check("be10_rd", 18'd5, 2'b10, 16'hFF00);
    rd_check("be00_rd", 18'd5, 2'b00, 16'h0000);

    // Address extremes.
    issue(1, 18'h3FFFF, 16'hA5A5, 2'b11, 0);
    issue(1, 18'h00000, 16'h5A5A, 2'b11, 0);
    rd_check("top_rd", 18'h3FFFF, 2'b11, 16'hA5A5);
    rd_check("zero_rd", 18'h00000, 2'b11, 16'h5A5A);

    // req held high with alternating write/read: one acceptance every S cycles.
    c0 = acc_cnt;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      issue(i[0] ? 1'b0 : 1'b1, 18'd200 + 18'(i/2), 16'h1000 + 16'(i), 2'b11, i != 9);
      if (i > 0) check("hold_spacing", cyc - prev, S);
      prev = cyc;
    end
    repeat (S) @(posedge CLOCK_50);
    #1;
    check("hold_accepts", acc_cnt - c0, 10);

    // Reset during RD_CAP aborts the read without an rvalid.
    c0 = rv_cnt;
    issue(0, 18'd13, 16'h0, 2'b11, 0);
    repeat (S-2) @(posedge CLOCK_50);
    #1;
    reset = 1;
    @(posedge CLOCK_50); #1;
    check("rcap_rvalid", rvalid, 0);
    check("rcap_ce_n", SRAM_CE_N, 1);
    check("rcap_oe_n", SRAM_OE_N, 1);
    check_z("rcap_dq");
    reset = 0; #1;
    check("rcap_ready", ready, 1);
    repeat (S) @(posedge CLOCK_50);
    #1;
    check("rcap_no_pulse", rv_cnt - c0, 0);
    rd_check("post_rst_rd", 18'd13, 2'b11, 16'h0002);

    // Randomized traffic over a small address pool, checked cycle by cycle.
    for (int i = 0; i < 400; i++) begin
      logic [17:0] a;
      bit h;
      case ($urandom_range(0, 7))
        0: a = 18'h00000;
        1: a = 18'h3FFFF;
        2: a = 18'h3FFFE;
        3: a = 18'd5;
        4: a = 18'd13;
        5: a = 18'd1;
        6: a = 18'd2;
        default: a = 18'($urandom);
      endcase
      h = ($urandom_range(0, 3) == 0) && (i != 399);
      issue(1'($urandom), a, 16'($urandom), 2'($urandom), h);
      if (!h) repeat ($urandom_range(0, 2)) begin @(posedge CLOCK_50); #1; end
    end
    req = 0;
    repeat (S + 1) @(posedge CLOCK_50);
    #1;
    check("total_accepts", acc_cnt, issued);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
